// File: rtl/ring_pkg.sv
// Shared types and constants for the ring playback path.
package ring_pkg;
  localparam int DATA_W_DEF = 14;
  localparam int LEN_W_DEF  = 7;
  localparam int DAC_W      = 16;
  localparam int DAC_SHIFT  = DAC_W - DATA_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;
endpackage

// File: rtl/stream_skid2.sv
// Two-entry output-registered valid/ready buffer; head entry drives the output.
module stream_skid2 #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  input  logic         pop_ready,
  output logic [1:0]   count
);
  logic [W-1:0] ent_p0, ent_p1;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign push_ready = (cnt_q < 2'd2);
  assign pop_valid  = (cnt_q != 2'd0);
  assign pop_data   = ent_p0;
  assign count      = cnt_q;
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      ent_p0 <= '0;
      ent_p1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent_p0 <= push_data;
          else               ent_p1 <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent_p0 <= ent_p1;
          cnt_q  <= cnt_q - 2'd1;
        end
        // simultaneous push/pop only happens with one entry held
        2'b11: ent_p0 <= push_data;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ring_streamer.sv
// Ring-to-AXI4-Stream playback engine: pops the ring's show-ahead head,
// frames each period with tlast and stops only on a period boundary.
module ring_streamer
  import ring_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  period_len,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              clear_err,
  input  logic [DATA_W-1:0] ring_dout,
  input  logic              ring_avail,
  output logic              ring_rd_en,
  output logic [DAC_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  localparam int SKID_W = DATA_W + 1;

  stream_state_e     state_q;
  logic [LEN_W-1:0]  period_len_q, sample_idx_q;
  logic [CNT_W-1:0]  burst_len_q, period_cnt_q;
  logic              stop_pend_q, halt_q, underrun_q, done_q;
  logic              start_ok, is_last, last_pop, halt_now, push_ready;
  logic              skid_vld;
  logic [SKID_W-1:0] skid_data;
  logic [1:0]        skid_count;

  assign start_ok   = (state_q == ST_IDLE) && start && (period_len != '0);
  assign ring_rd_en = (state_q == ST_RUN) && ring_avail && push_ready && !halt_q;
  assign is_last    = (sample_idx_q == period_len_q - LEN_W'(1));
  assign last_pop   = ring_rd_en && is_last;
  assign halt_now   = stop_pend_q || stop ||
                      ((burst_len_q != '0) && ((period_cnt_q + CNT_W'(1)) == burst_len_q));

  // ring head -> skid: captured on the same edge as the read enable
  stream_skid2 #(.W(SKID_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(ring_rd_en),
    .push_data ({is_last, ring_dout}),
    .push_ready(push_ready),
    .pop_valid (skid_vld),
    .pop_data  (skid_data),
    .pop_ready (m_axis_tready),
    .count     (skid_count)
  );

  assign m_axis_tvalid = skid_vld;
  assign m_axis_tdata  = {skid_data[DATA_W-1:0], {DAC_SHIFT{1'b0}}};
  assign m_axis_tlast  = skid_data[DATA_W];
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign underrun      = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_len_q <= '0;
      burst_len_q  <= '0;
      sample_idx_q <= '0;
      period_cnt_q <= '0;
      stop_pend_q  <= 1'b0;
      halt_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            period_len_q <= period_len;
            burst_len_q  <= burst_len;
            sample_idx_q <= '0;
            period_cnt_q <= '0;
            stop_pend_q  <= 1'b0;
            halt_q       <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) stop_pend_q <= 1'b1;
          if (ring_rd_en) begin
            if (is_last) begin
              sample_idx_q <= '0;
              period_cnt_q <= period_cnt_q + CNT_W'(1);
              if (halt_now) begin
                halt_q  <= 1'b1;
                state_q <= ST_DRAIN;
              end
            end else begin
              sample_idx_q <= sample_idx_q + LEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (skid_count == 2'd0) begin
            done_q  <= 1'b1;
            halt_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (clear_err || start_ok)
        underrun_q <= 1'b0;
      else if ((state_q == ST_RUN) && m_axis_tready && (skid_count == 2'd0) && !halt_q)
        underrun_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ring_streamer.sv
// Self-checking bench for ring_streamer: table runs, hand-written corner
// sequences and randomized backpressure against a stream-level model.
module tb_ring_streamer;
  import ring_pkg::*;
  localparam int DATA_W = 14;
  localparam int LEN_W  = 7;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, clear_err = 1'b0;
  logic [LEN_W-1:0]  period_len = '0;
  logic [CNT_W-1:0]  burst_len = '0;
  logic [DATA_W-1:0] ring_dout = '0;
  logic              ring_avail = 1'b0;
  logic              m_axis_tready = 1'b0;
  logic              ring_rd_en, m_axis_tvalid, m_axis_tlast, busy, done, underrun;
  logic [15:0]       m_axis_tdata;

  always #5 clk = ~clk;

  ring_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .period_len(period_len), .burst_len(burst_len), .clear_err(clear_err),
    .ring_dout(ring_dout), .ring_avail(ring_avail), .ring_rd_en(ring_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .underrun(underrun)
  );

  typedef struct {
    int plen;
    int burst;
    bit rnd;
    int exp_pops;
    int exp_lasts;
    int exp_done;
  } vec_t;
  vec_t tbl[6];

  int errors = 0, checks = 0;
  int cyc = 0, pops = 0, lasts = 0, done_cnt = 0, rd_cnt = 0, busy_cyc = 0;
  int last_xfer_cyc = -1, done_cyc = -1, busy_fall_cyc = -1;
  int plen_m = 1, popcnt_m = 0;
  int ring_val = 1;
  logic [14:0] exp_q[$];
  logic [16:0] out_log[$];
  logic        prev_stall = 1'b0, prev_busy = 1'b0;
  logic [15:0] prev_tdata = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, then update ring head and drop pulses.
  task automatic cycle();
    logic        popped;
    logic [14:0] e;
    @(negedge clk);
    cyc++;
    popped = ring_rd_en;
    chk("tvalid_vs_model", int'(m_axis_tvalid), int'(exp_q.size() != 0));
    if (ring_rd_en) chk("rd_en_legal", int'((exp_q.size() < 2) && ring_avail), 1);
    if (prev_stall) chk("stall_hold", int'(m_axis_tdata), int'(prev_tdata));
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", int'(m_axis_tdata), int'({e[13:0], 2'b00}));
        chk("tlast", int'(m_axis_tlast), int'(e[14]));
      end
      out_log.push_back({m_axis_tlast, m_axis_tdata});
      if (m_axis_tlast) lasts++;
      last_xfer_cyc = cyc;
    end
    if (ring_rd_en) begin
      exp_q.push_back({((popcnt_m % plen_m) == plen_m - 1), ring_dout});
      popcnt_m++;
      pops++;
      rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cyc++;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy  = busy;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_tdata = m_axis_tdata;
    @(posedge clk);
    #1;
    if (popped) ring_val++;
    ring_dout = DATA_W'(ring_val);
    start = 1'b0;
    stop = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic clear_counts();
    pops = 0; lasts = 0; done_cnt = 0; rd_cnt = 0; busy_cyc = 0;
    out_log.delete();
  endtask

  task automatic do_start(input int pl, input int bl, input bit acc);
    period_len = LEN_W'(pl);
    burst_len  = CNT_W'(bl);
    start = 1'b1;
    if (acc) begin
      plen_m = pl;
      popcnt_m = 0;
      clear_counts();
    end
    cycle();
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) begin
        m_axis_tready = ($urandom % 4) != 0;
        ring_avail    = ($urandom % 3) != 0;
      end
      cycle();
      n++;
    end
    chk("done_within_budget", int'(done_cnt != d0), 1);
    m_axis_tready = 1'b1;
    ring_avail = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4,   2, 1'b0, 8,   2, 1};
    tbl[1] = '{1,   3, 1'b0, 3,   3, 1};
    tbl[2] = '{7,   1, 1'b1, 7,   1, 1};
    tbl[3] = '{127, 1, 1'b0, 127, 1, 1};
    tbl[4] = '{3,   4, 1'b1, 12,  4, 1};
    tbl[5] = '{0,   2, 1'b0, 0,   0, 0};

    // reset values while rst_n is held low
    #3;
    chk("rst_rd_en", int'(ring_rd_en), 0);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_tlast", int'(m_axis_tlast), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ring_dout = DATA_W'(ring_val);

    // two periods of four, full throughput
    m_axis_tready = 1'b1;
    ring_avail = 1'b1;
    do_start(4, 2, 1'b1);
    run_until_done(100, 1'b0);
    chk("b1_rd_cycles", rd_cnt, 8);
    chk("b1_xfers", out_log.size(), 8);
    if (out_log.size() == 8) begin
      chk("b1_first", int'(out_log[0]), int'(17'h00004));
      chk("b1_tlast4", int'(out_log[3]), int'(17'h10010));
      chk("b1_fifth", int'(out_log[4]), int'(17'h00014));
      chk("b1_tlast8", int'(out_log[7]), int'(17'h10020));
    end
    // done rises on the edge after the final handshake edge
    chk("b1_done_timing", done_cyc, last_xfer_cyc + 2);
    chk("b1_busy_with_done", busy_fall_cyc, done_cyc);
    chk("b1_done_one_cycle", int'(done), 0);

    // table-driven runs
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = 1'b1;
      ring_avail = 1'b1;
      clear_counts();
      do_start(tbl[i].plen, tbl[i].burst, tbl[i].plen != 0);
      if (tbl[i].plen != 0) run_until_done(3000, tbl[i].rnd);
      else repeat (20) cycle();
      chk($sformatf("tbl%0d_pops", i), pops, tbl[i].exp_pops);
      chk($sformatf("tbl%0d_lasts", i), lasts, tbl[i].exp_lasts);
      chk($sformatf("tbl%0d_done", i), done_cnt, tbl[i].exp_done);
      chk($sformatf("tbl%0d_busy", i), int'(busy_cyc != 0), int'(tbl[i].plen != 0));
    end

    // stop mid-period in continuous mode
    do_start(5, 0, 1'b1);
    while (pops < 2) cycle();
    stop = 1'b1;
    cycle();
    run_until_done(100, 1'b0);
    chk("stop_pops", pops, 5);
    chk("stop_lasts", lasts, 1);

    // underrun set, sticky, cleared by clear_err and by start
    do_start(5, 0, 1'b1);
    repeat (4) cycle();
    clear_err = 1'b1;
    cycle();
    chk("ur_steady_clear", int'(underrun), 0);
    ring_avail = 1'b0;
    repeat (3) cycle();
    chk("ur_set", int'(underrun), 1);
    clear_err = 1'b1;
    cycle();
    chk("ur_clear_wins", int'(underrun), 0);
    cycle();
    chk("ur_set_again", int'(underrun), 1);
    ring_avail = 1'b1;
    repeat (2) cycle();
    chk("ur_sticky", int'(underrun), 1);
    clear_err = 1'b1;
    cycle();
    chk("ur_cleared", int'(underrun), 0);
    cycle();
    chk("ur_stays_clear", int'(underrun), 0);
    ring_avail = 1'b0;
    repeat (3) cycle();
    ring_avail = 1'b1;
    cycle();
    do_start(3, 1, 1'b0);
    chk("run_start_busy", int'(busy), 1);
    stop = 1'b1;
    cycle();
    run_until_done(100, 1'b0);
    chk("ur_pops_mult5", pops % 5, 0);
    chk("ur_held_idle", int'(underrun), 1);
    do_start(4, 1, 1'b1);
    chk("ur_start_clears", int'(underrun), 0);
    run_until_done(100, 1'b0);
    chk("ur_next_pops", pops, 4);

    // randomized bursts under random backpressure and ring gaps
    for (int r = 0; r < 8; r++) begin
      int pl, bl;
      pl = $urandom_range(1, 20);
      bl = $urandom_range(1, 4);
      do_start(pl, bl, 1'b1);
      run_until_done(4000, 1'b1);
      chk($sformatf("rnd%0d_pops", r), pops, pl * bl);
      chk($sformatf("rnd%0d_lasts", r), lasts, bl);
      chk($sformatf("rnd%0d_busy", r), int'(busy), 0);
    end
    for (int r = 0; r < 3; r++) begin
      int pl, k;
      pl = $urandom_range(2, 12);
      k  = $urandom_range(5, 60);
      do_start(pl, 0, 1'b1);
      for (int j = 0; j < k; j++) begin
        m_axis_tready = ($urandom % 4) != 0;
        ring_avail    = ($urandom % 3) != 0;
        cycle();
      end
      stop = 1'b1;
      run_until_done(4000, 1'b1);
      chk($sformatf("rstop%0d_mult", r), pops % pl, 0);
      chk($sformatf("rstop%0d_lasts", r), lasts, pops / pl);
    end

    // asynchronous reset with the skid full, then a clean restart
    m_axis_tready = 1'b0;
    ring_avail = 1'b1;
    do_start(10, 0, 1'b1);
    repeat (4) cycle();
    chk("ar_skid_full", exp_q.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rd_en", int'(ring_rd_en), 0);
    chk("ar_tvalid", int'(m_axis_tvalid), 0);
    chk("ar_tdata", int'(m_axis_tdata), 0);
    chk("ar_tlast", int'(m_axis_tlast), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_underrun", int'(underrun), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    prev_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    do_start(4, 1, 1'b1);
    run_until_done(100, 1'b0);
    chk("ar_restart_pops", pops, 4);
    chk("ar_restart_done", done_cnt, 1);
    if (out_log.size() == 4) chk("ar_restart_tlast", int'(out_log[3][16]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
